scr_ctrl: RTL and testbench

Bit-serial sequencer for one lane's scrambler. It sits between the lane's block framer and the scrambler's `data_in`/`enable`/`scr_rst` inputs. It tracks bit position inside each block and holds the LFSR still, passing bits unscrambled, during sync-header bits. It advances the LFSR for every payload bit and loads the seed at link start and on re-seed requests, only on block boundaries.

---
 rtl/scr_ctrl_pkg.sv | 38 +++
 rtl/scr_blk_cnt.sv | 53 +++++
 rtl/scr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_scr_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/scr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scr_ctrl_pkg
// Brief    : Shared types and block-geometry constants for the scrambler
//            sequencer (state enum, header/block lengths, bit_idx width).
// Revision : 1.0 - initial release
// ============================================================================
package scr_ctrl_pkg;

  // Width of the in-block bit position (largest block is 132 bits)
  localparam int BIDX_W = 8;

  // Gen2: 66-bit block, 2 sync-header bits
  localparam logic [BIDX_W-1:0] HLEN_G2 = 8'd2;
  localparam logic [BIDX_W-1:0] BLEN_G2 = 8'd66;
  // Gen3: 132-bit block, 4 sync-header bits
  localparam logic [BIDX_W-1:0] HLEN_G3 = 8'd4;
  localparam logic [BIDX_W-1:0] BLEN_G3 = 8'd132;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEED    = 2'd1,
    ST_HDR     = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  // Index of the last header bit for the selected format
  function automatic logic [BIDX_W-1:0] hdr_last(input logic g3);
    return g3 ? (HLEN_G3 - 8'd1) : (HLEN_G2 - 8'd1);
  endfunction

  // Index of the last bit in the block for the selected format
  function automatic logic [BIDX_W-1:0] blk_last(input logic g3);
    return g3 ? (BLEN_G3 - 8'd1) : (BLEN_G2 - 8'd1);
  endfunction

endpackage : scr_ctrl_pkg
`default_nettype wire

// File: rtl/scr_blk_cnt.sv
`default_nettype none
// ============================================================================
// Module   : scr_blk_cnt
// Brief    : In-block bit position counter. Advances per accepted bit, wraps
//            at the block end and flags the last header / last block bit
//            for the format latched by the controller.
// Revision : 1.0 - initial release
// ============================================================================
module scr_blk_cnt
  import scr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,        // synchronous, active-low
  input  logic              i_gen3,     // latched format select
  input  logic              i_clr,      // force position to 0
  input  logic              i_adv,      // a bit was accepted this cycle
  output logic [BIDX_W-1:0] o_bit_idx,
  output logic              o_hdr_end,  // position is the last header bit
  output logic              o_blk_end   // position is the last block bit
);

  logic [BIDX_W-1:0] bit_idx_q;
  logic [BIDX_W-1:0] bit_idx_d;

  // Header-end and block-end compares against the selected geometry
  always_comb begin
    o_hdr_end = (bit_idx_q == hdr_last(i_gen3));
    o_blk_end = (bit_idx_q == blk_last(i_gen3));
  end

  // Next position: clear, wrap at block end, or step on each accepted bit
  always_comb begin
    bit_idx_d = bit_idx_q;
    if (i_clr) begin
      bit_idx_d = '0;
    end else if (i_adv) begin
      bit_idx_d = o_blk_end ? '0 : (bit_idx_q + 8'd1);
    end
  end

  // Position register
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx_q <= '0;
    end else begin
      bit_idx_q <= bit_idx_d;
    end
  end

  assign o_bit_idx = bit_idx_q;

endmodule : scr_blk_cnt
`default_nettype wire

// File: rtl/scr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scr_ctrl
// Brief    : Bit-serial scrambler sequencer for one lane. Holds the LFSR
//            during sync-header bits, advances it on payload bits and loads
//            the seed at link start and on re-seed requests, only at block
//            boundaries.
//            Optional feature macro SCR_CTRL_RESEED_EN: automatic re-seed
//            every RESEED_BLOCKS blocks via a 16-bit block counter.
// Revision : 1.0 - initial release
// ============================================================================
module scr_ctrl
  import scr_ctrl_pkg::*;
#(
  parameter int unsigned RESEED_BLOCKS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gen3,
  input  logic       lane_start,
  input  logic       lane_stop,
  input  logic       reseed_req,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       scr_enable,
  output logic       scr_rst,
  output logic       hdr_bypass,
  output logic [7:0] bit_idx,
  output logic       blk_done,
  output logic       busy
);

  // Out-of-range RESEED_BLOCKS (0 or above 16 bits) has no meaningful build;
  // this empty marker block makes such an instantiation easy to spot.
  if ((RESEED_BLOCKS < 1) || (RESEED_BLOCKS > 65535)) begin : g_reseed_blocks_out_of_range
  end

  state_t state_q, state_d;
  logic   gen_q, gen_d;
  logic   stop_pend_q, stop_pend_d;
  logic   reseed_pend_q, reseed_pend_d;

  logic              w_active;
  logic              w_accept;
  logic              w_hdr_end;
  logic              w_blk_end;
  logic              w_blk_done;
  logic              w_cnt_hit;
  logic              w_stop_any;
  logic              w_reseed_any;
  logic [BIDX_W-1:0] w_bit_idx;

  assign w_active   = (state_q == ST_HDR) || (state_q == ST_PAYLOAD);
  assign w_accept   = w_active && in_valid;
  assign w_blk_done = (state_q == ST_PAYLOAD) && in_valid && w_blk_end;

  // Requests arriving on the block-end cycle itself count as pending
  assign w_stop_any   = stop_pend_q | lane_stop;
  assign w_reseed_any = reseed_pend_q | reseed_req | w_cnt_hit;

  scr_blk_cnt u_blk_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_gen3    (gen_q),
    .i_clr     (!w_active),
    .i_adv     (w_accept),
    .o_bit_idx (w_bit_idx),
    .o_hdr_end (w_hdr_end),
    .o_blk_end (w_blk_end)
  );

`ifdef SCR_CTRL_RESEED_EN
  localparam logic [15:0] RESEED_TGT = 16'(RESEED_BLOCKS);

  logic [15:0] blk_cnt_q, blk_cnt_d;

  // Block counter: counts completed blocks since the last seed load
  always_comb begin
    w_cnt_hit = w_blk_done && ((blk_cnt_q + 16'd1) == RESEED_TGT);
    blk_cnt_d = blk_cnt_q;
    if (state_q == ST_SEED) begin
      blk_cnt_d = '0;
    end else if (w_blk_done) begin
      blk_cnt_d = w_cnt_hit ? 16'd0 : (blk_cnt_q + 16'd1);
    end
  end

  // Block counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end
`else
  assign w_cnt_hit = 1'b0;
`endif

  // Next-state and pending-flag logic
  always_comb begin
    state_d       = state_q;
    gen_d         = gen_q;
    stop_pend_d   = stop_pend_q;
    reseed_pend_d = reseed_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (lane_start) begin
          state_d = ST_SEED;
          gen_d   = gen3;
        end
      end
      ST_SEED: begin
        state_d       = ST_HDR;
        reseed_pend_d = 1'b0;
        stop_pend_d   = 1'b0;
      end
      ST_HDR: begin
        stop_pend_d   = w_stop_any;
        reseed_pend_d = reseed_pend_q | reseed_req;
        if (in_valid && w_hdr_end) begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        stop_pend_d   = w_stop_any;
        reseed_pend_d = reseed_pend_q | reseed_req;
        if (w_blk_done) begin
          if (w_stop_any) begin
            state_d       = ST_IDLE;
            stop_pend_d   = 1'b0;
            reseed_pend_d = 1'b0;
          end else if (w_reseed_any) begin
            state_d       = ST_SEED;
            reseed_pend_d = 1'b1;
          end else begin
            state_d = ST_HDR;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      gen_q         <= 1'b0;
      stop_pend_q   <= 1'b0;
      reseed_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gen_q         <= gen_d;
      stop_pend_q   <= stop_pend_d;
      reseed_pend_q <= reseed_pend_d;
    end
  end

  // Output decode: strobes follow the bit being presented
  always_comb begin
    in_ready   = w_active;
    scr_enable = (state_q == ST_PAYLOAD) && in_valid;
    hdr_bypass = (state_q == ST_HDR) && in_valid;
    scr_rst    = (state_q == ST_SEED);
    blk_done   = w_blk_done;
    busy       = (state_q != ST_IDLE);
    bit_idx    = w_bit_idx;
  end

endmodule : scr_ctrl
`default_nettype wire

// File: tb/tb_scr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scr_ctrl
// Brief    : Self-checking bench for scr_ctrl. A block-position model
//            predicts every output each cycle under directed and random
//            stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scr_ctrl;

  localparam int unsigned RB = 3;
`ifdef SCR_CTRL_RESEED_EN
  localparam bit M_AUTO = 1'b1;
`else
  localparam bit M_AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, gen3, lane_start, lane_stop, reseed_req, in_valid;
  logic       in_ready, scr_enable, scr_rst, hdr_bypass, blk_done, busy;
  logic [7:0] bit_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Model: link running, seed cycle, position, format, pending requests
  bit m_run, m_seed, m_g3, m_stop, m_reseed;
  int m_pos, m_blocks;

  always #5 clk = ~clk;

  scr_ctrl #(.RESEED_BLOCKS(RB)) dut (
    .clk(clk), .rst(rst), .gen3(gen3), .lane_start(lane_start),
    .lane_stop(lane_stop), .reseed_req(reseed_req), .in_valid(in_valid),
    .in_ready(in_ready), .scr_enable(scr_enable), .scr_rst(scr_rst),
    .hdr_bypass(hdr_bypass), .bit_idx(bit_idx), .blk_done(blk_done),
    .busy(busy)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int blen();
    return m_g3 ? 132 : 66;
  endfunction

  function automatic int hlen();
    return m_g3 ? 4 : 2;
  endfunction

  // Compare every output with the model's prediction for the current cycle
  task automatic check_outputs();
    bit taking;
    taking = m_run && !m_seed;
    check_eq("in_ready",   int'(in_ready),   int'(taking));
    check_eq("scr_rst",    int'(scr_rst),    int'(m_run && m_seed));
    check_eq("busy",       int'(busy),       int'(m_run));
    check_eq("bit_idx",    int'(bit_idx),    m_pos);
    check_eq("hdr_bypass", int'(hdr_bypass), int'(taking && in_valid && (m_pos < hlen())));
    check_eq("scr_enable", int'(scr_enable), int'(taking && in_valid && (m_pos >= hlen())));
    check_eq("blk_done",   int'(blk_done),   int'(taking && in_valid && (m_pos == blen() - 1)));
  endtask

  // Advance the model by one clock edge using the inputs presented
  task automatic model_edge();
    if (!rst) begin
      m_run = 0; m_seed = 0; m_g3 = 0; m_stop = 0; m_reseed = 0;
      m_pos = 0; m_blocks = 0;
    end else if (!m_run) begin
      if (lane_start) begin
        m_run = 1; m_seed = 1; m_g3 = gen3;
      end
    end else if (m_seed) begin
      m_seed = 0; m_pos = 0; m_reseed = 0; m_blocks = 0;
    end else begin
      if (lane_stop)  m_stop = 1;
      if (reseed_req) m_reseed = 1;
      if (in_valid) begin
        if (m_pos == blen() - 1) begin
          m_pos = 0;
          m_blocks++;
          if (M_AUTO && m_blocks == int'(RB)) begin
            m_blocks = 0;
            m_reseed = 1;
          end
          if (m_stop) begin
            m_run = 0; m_stop = 0; m_reseed = 0;
          end else if (m_reseed) begin
            m_seed = 1;
          end
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  // One clock: check mid-cycle, apply the edge to the model, clear pulses
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #4;
      check_outputs();
      @(posedge clk);
      model_edge();
      #1;
      lane_start = 0; lane_stop = 0; reseed_req = 0;
    end
  endtask

  // Step until the model is consuming bits at position p (bounded)
  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (!(m_run && !m_seed && m_pos == p) && k < 400) begin
      run(1);
      k++;
    end
    check_eq("wait_pos", m_pos, p);
  endtask

  task automatic start_lane(input logic g);
    gen3 = g; lane_start = 1;
    run(1);
  endtask

  initial begin
    rst = 0; gen3 = 0; lane_start = 0; lane_stop = 0; reseed_req = 0; in_valid = 0;
    m_run = 0; m_seed = 0; m_g3 = 0; m_stop = 0; m_reseed = 0; m_pos = 0; m_blocks = 0;
    @(posedge clk); #1;
    run(3);
    rst = 1;
    run(2);

    // Gen2 link start, continuous bits for two blocks
    in_valid = 1;
    start_lane(1'b0);
    run(140);

    // Re-seed request mid-block
    wait_pos(10);
    reseed_req = 1;
    run(150);

    // Stop and re-seed both pending at block end
    wait_pos(20);
    lane_stop = 1; reseed_req = 1;
    run(80);

    // Gen3 start, continuous bits
    start_lane(1'b1);
    run(150);

    // Valid gap inside the payload
    wait_pos(30);
    in_valid = 0; run(1);
    in_valid = 1; run(1);
    in_valid = 0; run(2);
    in_valid = 1; run(5);

    // Reset mid-block at Gen3 bit 70, then restart
    wait_pos(70);
    rst = 0; run(1);
    rst = 1; run(3);
    start_lane(1'b1);
    run(600);

    // Randomised traffic
    for (int i = 0; i < 5000; i++) begin
      rst        = ($urandom_range(0, 999) >= 3);
      lane_start = ($urandom_range(0, 99) < 4);
      lane_stop  = ($urandom_range(0, 199) < 1);
      reseed_req = ($urandom_range(0, 199) < 2);
      in_valid   = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 49) == 0) gen3 = ~gen3;
      run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_scr_ctrl
`default_nettype wire
